// File: rtl/inv_sbox_word_iter_if.sv
// Word stream bundle for the iterative inverse S-box block:
// an input word handshake, an output word handshake, and busy status.
interface inv_sbox_word_iter_if #(
    parameter int BYTES = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [8*BYTES-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [8*BYTES-1:0] out_data;
    logic               busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/inv_sbox_word_iter.sv
// Byte-serial AES InvSubBytes over a word: one shared InvS,
// processing one byte per clock, bytes 0 to BYTES-1.
module inv_sbox_word_iter #(
    parameter int BYTES = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    inv_sbox_word_iter_if.slave bus
);
    localparam int W  = 8 * BYTES;
    localparam int CW = $clog2(BYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_s(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]}
          ^ {a[4:0], a[7:5]}
          ^ {a[1:0], a[7:2]}
          ^ 8'h05;
        return gf_inv(b);
    endfunction

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  din;
    logic [W-1:0]  work;
    logic [W-1:0]  dout;
    logic [7:0]    sel;
    logic [7:0]    sub;
    logic [W-1:0]  next_work;

    always_comb begin
        sel = 8'h00;
        for (int k = 0; k < BYTES; k++) begin
            if (cnt == CW'(k)) sel = din[8*k +: 8];
        end
    end

    assign sub = inv_s(sel);

    always_comb begin
        next_work = work;
        for (int k = 0; k < BYTES; k++) begin
            if (cnt == CW'(k)) next_work[8*k +: 8] = sub;
        end
    end

    // work fills byte by byte; dout only changes on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            din   <= '0;
            work  <= '0;
            dout  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        din   <= bus.in_data;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    work <= next_work;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        dout  <= next_work;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_data  = dout;
endmodule

// File: tb/tb_inv_sbox_word_iter.sv
// Scoreboard bench for inv_sbox_word_iter: BYTES=4 and BYTES=1
// instances, latency, throughput, backpressure and reset abort.
module tb_inv_sbox_word_iter;
    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    logic [31:0] sbq[$];
    logic [7:0]  q1[$];

    inv_sbox_word_iter_if #(.BYTES(4)) bus ();
    inv_sbox_word_iter_if #(.BYTES(1)) bus1 ();

    inv_sbox_word_iter #(.BYTES(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    inv_sbox_word_iter #(.BYTES(1)) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // forward AES S-box, used only to build exhaustive stimulus
    function automatic logic [7:0] fwd_s(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = tb_mul(r, x);
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] exh_exp(input int x);
        logic [7:0] b;
        b = 8'(x);
        return {b ^ 8'h03, b ^ 8'h02, b ^ 8'h01, b};
    endfunction

    function automatic logic [31:0] exh_word(input int x);
        logic [31:0] e;
        e = exh_exp(x);
        return {fwd_s(e[31:24]), fwd_s(e[23:16]), fwd_s(e[15:8]), fwd_s(e[7:0])};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [31:0] e);
        int n;
        n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        sbq.push_back(e);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.out_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: rdy=%b vld=%b busy=%b data=%h want 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_data);
        end
        vectors++;
        if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0 ||
            bus1.out_data !== 8'h0) begin
            miscompares++;
            $display("FAIL reset1: rdy=%b vld=%b data=%h want 1 0 00",
                     bus1.in_ready, bus1.out_valid, bus1.out_data);
        end
    endtask

    task automatic test_word(input logic [31:0] d, input logic [31:0] e);
        int cyc;
        logic [31:0] x;
        send(d, e);
        wait_out(cyc);
        vectors++;
        if (cyc !== 4) begin
            miscompares++;
            $display("FAIL latency %h: got %0d want 4", d, cyc);
        end
        x = sbq.pop_front();
        vectors++;
        if (bus.out_data !== x) begin
            miscompares++;
            $display("FAIL data %h: got %h want %h", d, bus.out_data, x);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL handshake %h: rdy=%b vld=%b want 1 0",
                     d, bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_basic();
        test_word(32'h16ED7C63, 32'hFF530100);
    endtask

    task automatic test_edges();
        test_word(32'h00000000, 32'h52525252);
        test_word(32'h63636363, 32'h00000000);
    endtask

    task automatic test_back_to_back();
        int idx;
        int got;
        int cyc;
        int last;
        logic [31:0] e;
        idx = 0;
        got = 0;
        cyc = 0;
        last = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = exh_word(0);
        while (got < 256 && cyc < 2000) begin
            bit acc;
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                vectors++;
                if (sbq.size() == 0) begin
                    miscompares++;
                    $display("FAIL exh_extra: got %h want nothing", bus.out_data);
                end else begin
                    e = sbq.pop_front();
                    if (bus.out_data !== e) begin
                        miscompares++;
                        $display("FAIL exh %0d: got %h want %h", got, bus.out_data, e);
                    end
                end
                got++;
            end
            if (acc) begin
                sbq.push_back(exh_exp(idx));
                if (idx > 0) begin
                    vectors++;
                    if (cyc - last != 6) begin
                        miscompares++;
                        $display("FAIL gap %0d: got %0d want 6", idx, cyc - last);
                    end
                end
                last = cyc;
            end
            tick();
            cyc++;
            if (acc) begin
                idx++;
                if (idx == 256) bus.in_valid = 1'b0;
                else bus.in_data = exh_word(idx);
            end
        end
        vectors++;
        if (got != 256) begin
            miscompares++;
            $display("FAIL exh_timeout: got %0d words want 256", got);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        sbq.delete();
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [31:0] x;
        send(32'h16ED7C63, 32'hFF530100);
        wait_out(cyc);
        x = sbq.pop_front();
        vectors++;
        if (cyc !== 4) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d want 4", cyc);
        end
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_data = $urandom();
            tick();
            vectors++;
            if (bus.out_data !== x || bus.in_ready !== 1'b0 ||
                bus.out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall %0d: data=%h rdy=%b vld=%b want %h 0 1",
                         i, bus.out_data, bus.in_ready, bus.out_valid, x);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL one_shot %0d: vld=%b rdy=%b want 0 1",
                         i, bus.out_valid, bus.in_ready);
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cyc;
        send(32'h11223344, 32'h0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 ||
            bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid: vld=%b data=%h busy=%b rdy=%b want 0 0 0 1",
                     bus.out_valid, bus.out_data, bus.busy, bus.in_ready);
        end
        sbq.delete();
        tick();
        rst_n = 1'b1;
        tick();
        test_word(32'h00000000, 32'h52525252);
        send(32'h63636363, 32'h0);
        wait_out(cyc);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_done: vld=%b data=%h want 0 0",
                     bus.out_valid, bus.out_data);
        end
        sbq.delete();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bytes1();
        logic [7:0] x;
        bus1.in_data  = 8'hED;
        bus1.in_valid = 1'b1;
        q1.push_back(8'h53);
        tick();
        bus1.in_valid = 1'b0;
        vectors++;
        if (bus1.out_valid !== 1'b0 || bus1.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b1_accept: vld=%b busy=%b want 0 1",
                     bus1.out_valid, bus1.busy);
        end
        tick();
        x = q1.pop_front();
        vectors++;
        if (bus1.out_valid !== 1'b1 || bus1.out_data !== x) begin
            miscompares++;
            $display("FAIL b1_data: vld=%b data=%h want 1 %h",
                     bus1.out_valid, bus1.out_data, x);
        end
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        vectors++;
        if (bus1.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b1_ready: got %b want 1", bus1.in_ready);
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = '0;
        bus1.out_ready = 1'b0;
        tick();
        test_reset();
        tick();
        rst_n = 1'b1;
        tick();
        test_basic();
        test_edges();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_bytes1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
